// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard/stall controller.
// Holds the state encoding, the default register address width and the R0 index.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_MC   = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  localparam int REG_AW_DEF = 4;
  localparam int R0_IDX     = 0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with enable and asynchronous active-high reset.
// It stops at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (en && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard and stall controller for the 5-stage pipeline. It detects load-use and
// branch-in-ID hazards, sequences multi-cycle EX ops and handles halt.
module pipe_hazard_unit
  import pipe_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF,
  parameter int MC_LAT = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_ra1,
  input  logic [REG_AW-1:0] id_ra2,
  input  logic              id_use1,
  input  logic              id_use2,
  input  logic              id_use_r0,
  input  logic              id_is_branch,
  input  logic              id_br_taken,
  input  logic              id_is_mc,
  input  logic              id_halt,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              ex_regwrite,
  input  logic              mem_regwrite,
  input  logic              ex_r0write,
  input  logic              ex_memread,
  input  logic              mem_memread,
  output logic              pc_stall,
  output logic              ifid_stall,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic              ex_hold,
  output logic              mc_busy,
  output logic              halted,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int MC_W = $clog2(MC_LAT + 1);

  state_t          state, state_next;
  logic [MC_W-1:0] mc_cnt, mc_next;
  logic            lu, bh, stall;
  logic            cnt_en;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_RUN;
      mc_cnt <= '0;
    end else begin
      state  <= state_next;
      mc_cnt <= mc_next;
    end
  end

  always_comb begin
    state_next  = state;
    mc_next     = mc_cnt;
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    ex_hold     = 1'b0;
    mc_busy     = 1'b0;
    halted      = 1'b0;

    lu = ex_memread & ex_regwrite &
         ((id_use1 & (ex_rd == id_ra1)) | (id_use2 & (ex_rd == id_ra2)));
    bh = id_is_branch &
         ((ex_regwrite & (ex_rd == id_ra1)) |
          (mem_memread & mem_regwrite & (mem_rd == id_ra1)) |
          (id_use_r0 & ex_r0write));
    stall = id_valid & (lu | bh);

    case (state)
      ST_RUN: begin
        if (stall) begin
          // A taken branch must not flush while its operands are still in flight.
          pc_stall    = 1'b1;
          ifid_stall  = 1'b1;
          idex_bubble = 1'b1;
        end else if (id_valid) begin
          ifid_flush = id_is_branch & id_br_taken;
          if (id_halt) begin
            state_next = ST_HALT;
          end else if (id_is_mc) begin
            state_next = ST_MC;
            mc_next    = MC_W'(MC_LAT - 1);
          end
        end
      end
      ST_MC: begin
        pc_stall   = 1'b1;
        ifid_stall = 1'b1;
        ex_hold    = 1'b1;
        mc_busy    = 1'b1;
        mc_next    = mc_cnt - MC_W'(1);
        if (mc_cnt <= MC_W'(1)) begin
          state_next = ST_RUN;
          mc_next    = '0;
        end
      end
      ST_HALT: begin
        pc_stall   = 1'b1;
        ifid_flush = 1'b1;
        halted     = 1'b1;
      end
      default: begin
        state_next = ST_RUN;
        mc_next    = '0;
      end
    endcase

    // Outputs read as idle for the whole time reset is held, not only after the next edge.
    if (reset) begin
      pc_stall    = 1'b0;
      ifid_stall  = 1'b0;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      ex_hold     = 1'b0;
      mc_busy     = 1'b0;
      halted      = 1'b0;
    end
  end

  assign cnt_en = pc_stall & (state != ST_HALT);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (cnt_en),
    .count (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Self-checking bench for pipe_hazard_unit: directed scenarios plus a randomized
// run against a cycle-level reference model, on three parameter variants.
module tb_pipe_hazard_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid, id_use1, id_use2, id_use_r0, id_is_branch, id_br_taken;
  logic       id_is_mc, id_halt, ex_regwrite, mem_regwrite, ex_r0write;
  logic       ex_memread, mem_memread;
  logic [3:0] id_ra1, id_ra2, ex_rd, mem_rd;

  // Output vector order: {pc_stall, ifid_stall, ifid_flush, idex_bubble, ex_hold, mc_busy, halted}
  logic [6:0]  obs [3];
  logic [15:0] cnt_obs [3];
  logic [6:0]  o0, o1, o2;
  logic [15:0] c0, c1;
  logic [3:0]  c2;

  localparam logic [6:0] V_IDLE  = 7'b0000000;
  localparam logic [6:0] V_STALL = 7'b1101000;
  localparam logic [6:0] V_FLUSH = 7'b0010000;
  localparam logic [6:0] V_MC    = 7'b1100110;
  localparam logic [6:0] V_HALT  = 7'b1010001;

  int n_cmp = 0;
  int n_fail = 0;

  int     k_lat [3] = '{4, 2, 4};
  longint k_max [3] = '{65535, 65535, 15};
  int     m_mc_left [3];
  bit     m_halt [3];
  longint m_cnt [3];

  always #5 clk = ~clk;

  pipe_hazard_unit #(.REG_AW(4), .MC_LAT(4), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_ra1(id_ra1), .id_ra2(id_ra2),
    .id_use1(id_use1), .id_use2(id_use2), .id_use_r0(id_use_r0), .id_is_branch(id_is_branch),
    .id_br_taken(id_br_taken), .id_is_mc(id_is_mc), .id_halt(id_halt), .ex_rd(ex_rd),
    .mem_rd(mem_rd), .ex_regwrite(ex_regwrite), .mem_regwrite(mem_regwrite),
    .ex_r0write(ex_r0write), .ex_memread(ex_memread), .mem_memread(mem_memread),
    .pc_stall(o0[6]), .ifid_stall(o0[5]), .ifid_flush(o0[4]), .idex_bubble(o0[3]),
    .ex_hold(o0[2]), .mc_busy(o0[1]), .halted(o0[0]), .stall_cnt(c0));

  pipe_hazard_unit #(.REG_AW(4), .MC_LAT(2), .CNT_W(16)) dut_mc2 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_ra1(id_ra1), .id_ra2(id_ra2),
    .id_use1(id_use1), .id_use2(id_use2), .id_use_r0(id_use_r0), .id_is_branch(id_is_branch),
    .id_br_taken(id_br_taken), .id_is_mc(id_is_mc), .id_halt(id_halt), .ex_rd(ex_rd),
    .mem_rd(mem_rd), .ex_regwrite(ex_regwrite), .mem_regwrite(mem_regwrite),
    .ex_r0write(ex_r0write), .ex_memread(ex_memread), .mem_memread(mem_memread),
    .pc_stall(o1[6]), .ifid_stall(o1[5]), .ifid_flush(o1[4]), .idex_bubble(o1[3]),
    .ex_hold(o1[2]), .mc_busy(o1[1]), .halted(o1[0]), .stall_cnt(c1));

  pipe_hazard_unit #(.REG_AW(4), .MC_LAT(4), .CNT_W(4)) dut_c4 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_ra1(id_ra1), .id_ra2(id_ra2),
    .id_use1(id_use1), .id_use2(id_use2), .id_use_r0(id_use_r0), .id_is_branch(id_is_branch),
    .id_br_taken(id_br_taken), .id_is_mc(id_is_mc), .id_halt(id_halt), .ex_rd(ex_rd),
    .mem_rd(mem_rd), .ex_regwrite(ex_regwrite), .mem_regwrite(mem_regwrite),
    .ex_r0write(ex_r0write), .ex_memread(ex_memread), .mem_memread(mem_memread),
    .pc_stall(o2[6]), .ifid_stall(o2[5]), .ifid_flush(o2[4]), .idex_bubble(o2[3]),
    .ex_hold(o2[2]), .mc_busy(o2[1]), .halted(o2[0]), .stall_cnt(c2));

  assign obs[0] = o0;
  assign obs[1] = o1;
  assign obs[2] = o2;
  assign cnt_obs[0] = c0;
  assign cnt_obs[1] = c1;
  assign cnt_obs[2] = {12'b0, c2};

  // Reference model: a core either is halted, is still owed some multi-cycle stall
  // cycles, or runs; in the running case the ID instruction waits if a hazard applies.
  function automatic bit hazard_now();
    bit load_use, branch_dep;
    load_use = ex_memread && ex_regwrite &&
               ((id_use1 && ex_rd == id_ra1) || (id_use2 && ex_rd == id_ra2));
    branch_dep = id_is_branch &&
                 ((ex_regwrite && ex_rd == id_ra1) ||
                  (mem_memread && mem_regwrite && mem_rd == id_ra1) ||
                  (id_use_r0 && ex_r0write));
    return id_valid && (load_use || branch_dep);
  endfunction

  function automatic logic [6:0] exp_vec(int k);
    if (m_halt[k]) return V_HALT;
    if (m_mc_left[k] > 0) return V_MC;
    if (hazard_now()) return V_STALL;
    return (id_valid && id_is_branch && id_br_taken) ? V_FLUSH : V_IDLE;
  endfunction

  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      if (m_halt[k]) continue;
      if (m_mc_left[k] > 0 || hazard_now()) begin
        if (m_mc_left[k] > 0) m_mc_left[k]--;
        if (m_cnt[k] < k_max[k]) m_cnt[k]++;
      end else if (id_valid && id_halt) begin
        m_halt[k] = 1'b1;
      end else if (id_valid && id_is_mc) begin
        m_mc_left[k] = k_lat[k] - 1;
      end
    end
  endtask

  task automatic clear_inputs();
    id_valid = 0; id_use1 = 0; id_use2 = 0; id_use_r0 = 0; id_is_branch = 0;
    id_br_taken = 0; id_is_mc = 0; id_halt = 0; ex_regwrite = 0; mem_regwrite = 0;
    ex_r0write = 0; ex_memread = 0; mem_memread = 0;
    id_ra1 = 0; id_ra2 = 0; ex_rd = 0; mem_rd = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      m_mc_left[k] = 0; m_halt[k] = 0; m_cnt[k] = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_load_use();
    id_valid = 1; ex_memread = 1; ex_regwrite = 1; ex_rd = 4'd3; id_ra1 = 4'd3; id_use1 = 1;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (obs[k] !== V_IDLE) begin
        n_fail++; $display("FAIL reset_out[%0d] got %b want %b", k, obs[k], V_IDLE);
      end
      n_cmp++;
      if (cnt_obs[k] !== 16'd0) begin
        n_fail++; $display("FAIL reset_cnt[%0d] got %0d want 0", k, cnt_obs[k]);
      end
    end
    do_reset();
  endtask

  task automatic test_load_use();
    do_reset();
    set_load_use();
    #1;
    n_cmp++;
    if (obs[0] !== V_STALL) begin
      n_fail++; $display("FAIL lu_stall got %b want %b", obs[0], V_STALL);
    end
    tick();
    ex_memread = 0;
    #1;
    n_cmp++;
    if (obs[0] !== V_IDLE) begin
      n_fail++; $display("FAIL lu_release got %b want %b", obs[0], V_IDLE);
    end
    n_cmp++;
    if (c0 !== 16'd1) begin
      n_fail++; $display("FAIL lu_cnt got %0d want 1", c0);
    end
  endtask

  task automatic test_branch();
    do_reset();
    id_valid = 1; id_is_branch = 1; id_br_taken = 1;
    mem_memread = 1; mem_regwrite = 1; mem_rd = 4'd5; id_ra1 = 4'd5;
    #1;
    n_cmp++;
    if (obs[0] !== V_STALL) begin
      n_fail++; $display("FAIL br_stall got %b want %b", obs[0], V_STALL);
    end
    tick();
    mem_memread = 0;
    #1;
    n_cmp++;
    if (obs[0] !== V_FLUSH) begin
      n_fail++; $display("FAIL br_flush got %b want %b", obs[0], V_FLUSH);
    end
    n_cmp++;
    if (c0 !== 16'd1) begin
      n_fail++; $display("FAIL br_cnt got %0d want 1", c0);
    end
  endtask

  task automatic test_multi_cycle();
    do_reset();
    id_valid = 1; id_is_mc = 1;
    #1;
    n_cmp++;
    if (obs[0] !== V_IDLE) begin
      n_fail++; $display("FAIL mc_issue got %b want %b", obs[0], V_IDLE);
    end
    tick();
    id_is_mc = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++;
      if (obs[0] !== ((i < 3) ? V_MC : V_IDLE)) begin
        n_fail++; $display("FAIL mc4_cycle%0d got %b want %b", i, obs[0], (i < 3) ? V_MC : V_IDLE);
      end
      n_cmp++;
      if (obs[1] !== ((i < 1) ? V_MC : V_IDLE)) begin
        n_fail++; $display("FAIL mc2_cycle%0d got %b want %b", i, obs[1], (i < 1) ? V_MC : V_IDLE);
      end
      tick();
    end
    n_cmp++;
    if (c0 !== 16'd3) begin
      n_fail++; $display("FAIL mc4_cnt got %0d want 3", c0);
    end
    n_cmp++;
    if (c1 !== 16'd1) begin
      n_fail++; $display("FAIL mc2_cnt got %0d want 1", c1);
    end
  endtask

  task automatic test_halt();
    do_reset();
    set_load_use();
    tick();
    clear_inputs();
    id_valid = 1; id_halt = 1; id_is_mc = 1;
    #1;
    n_cmp++;
    if (obs[0] !== V_IDLE) begin
      n_fail++; $display("FAIL halt_issue got %b want %b", obs[0], V_IDLE);
    end
    tick();
    for (int i = 0; i < 20; i++) begin
      id_valid = 1'($urandom_range(0, 1)); id_is_mc = 1'($urandom_range(0, 1));
      ex_memread = 1; ex_regwrite = 1; id_use1 = 1; ex_rd = 4'd7; id_ra1 = 4'd7;
      #1;
      n_cmp++;
      if (obs[0] !== V_HALT) begin
        n_fail++; $display("FAIL halt_hold%0d got %b want %b", i, obs[0], V_HALT);
      end
      n_cmp++;
      if (c0 !== 16'd1) begin
        n_fail++; $display("FAIL halt_cnt%0d got %0d want 1", i, c0);
      end
      tick();
    end
  endtask

  task automatic test_saturation();
    do_reset();
    set_load_use();
    for (int i = 1; i <= 20; i++) begin
      tick();
      n_cmp++;
      if (c2 !== 4'((i < 15) ? i : 15)) begin
        n_fail++; $display("FAIL sat_cnt%0d got %0d want %0d", i, c2, (i < 15) ? i : 15);
      end
    end
    n_cmp++;
    if (c0 !== 16'd20) begin
      n_fail++; $display("FAIL sat_wide_cnt got %0d want 20", c0);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    id_valid = 1; id_is_mc = 1;
    tick();
    id_is_mc = 0;
    tick();
    #3;
    reset = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (obs[k] !== V_IDLE) begin
        n_fail++; $display("FAIL ares_out[%0d] got %b want %b", k, obs[k], V_IDLE);
      end
      n_cmp++;
      if (cnt_obs[k] !== 16'd0) begin
        n_fail++; $display("FAIL ares_cnt[%0d] got %0d want 0", k, cnt_obs[k]);
      end
    end
    #1;
    reset = 1'b0;
    #1;
    n_cmp++;
    if (obs[0] !== V_IDLE) begin
      n_fail++; $display("FAIL ares_release got %b want %b", obs[0], V_IDLE);
    end
    tick();
    n_cmp++;
    if (obs[0] !== V_IDLE) begin
      n_fail++; $display("FAIL ares_no_hold got %b want %b", obs[0], V_IDLE);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if (cyc % 200 == 199) do_reset();
      id_valid = ($urandom_range(0, 9) != 0);
      id_ra1 = 4'($urandom_range(0, 3)); id_ra2 = 4'($urandom_range(0, 3));
      ex_rd = 4'($urandom_range(0, 3)); mem_rd = 4'($urandom_range(0, 3));
      id_use1 = 1'($urandom_range(0, 1)); id_use2 = 1'($urandom_range(0, 1));
      id_use_r0 = 1'($urandom_range(0, 1)); id_is_branch = 1'($urandom_range(0, 1));
      id_br_taken = 1'($urandom_range(0, 1)); ex_regwrite = 1'($urandom_range(0, 1));
      mem_regwrite = 1'($urandom_range(0, 1)); ex_r0write = ($urandom_range(0, 3) == 0);
      ex_memread = 1'($urandom_range(0, 1)); mem_memread = 1'($urandom_range(0, 1));
      id_is_mc = ($urandom_range(0, 7) == 0); id_halt = ($urandom_range(0, 149) == 0);
      #1;
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (obs[k] !== exp_vec(k)) begin
          n_fail++; $display("FAIL rand_out[%0d] cyc %0d got %b want %b", k, cyc, obs[k], exp_vec(k));
        end
        n_cmp++;
        if (cnt_obs[k] !== 16'(m_cnt[k])) begin
          n_fail++; $display("FAIL rand_cnt[%0d] cyc %0d got %0d want %0d", k, cyc, cnt_obs[k], m_cnt[k]);
        end
      end
      model_step();
      tick();
    end
  endtask

  initial begin
    clear_inputs();
    reset = 1'b0;
    #1;
    test_reset();
    test_load_use();
    test_branch();
    test_multi_cycle();
    test_halt();
    test_saturation();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_unit.md
Name: pipe_hazard_unit

Overview:
- Parametrised hazard and stall controller for the 16-bit 5-stage pipeline. It replaces the single externally driven Hazard pin.
- Generates PC/IF-ID stall, IF-ID flush, ID-EX bubble and EX hold from register-address compares, branch-in-ID resolution, multi-cycle ALU ops and halt.
- Sits beside the control unit in ID. Its outputs drive the PC, IFIDBuffer, IDEXBuffer and EXMEMBuffer enables.

Parameters:
- REG_AW, 4: register address width.
- MC_LAT, 4: total EX-stage cycles of a multi-cycle op (mul/div); legal range 2..15.
- CNT_W, 16: width of the saturating stall-cycle counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_ra1, id_ra2  in  REG_AW  ID source register addresses.
- id_use1, id_use2  in  1  ID instruction reads ra1 / ra2.
- id_use_r0  in  1  ID instruction reads R0.
- id_is_branch  in  1  branch resolved in ID.
- id_br_taken  in  1  branch unit decision, valid when id_is_branch.
- id_is_mc  in  1  multi-cycle ALU op.
- id_halt  in  1  halt opcode decoded.
- ex_rd, mem_rd  in  REG_AW  destination register in EX / MEM.
- ex_regwrite, mem_regwrite  in  1  register write enables per stage.
- ex_r0write  in  1  EX instruction writes R0.
- ex_memread, mem_memread  in  1  load in EX / MEM.
- pc_stall  out  1  hold PC.
- ifid_stall  out  1  hold IF/ID.
- ifid_flush  out  1  load bubble into IF/ID.
- idex_bubble  out  1  load bubble into ID/EX.
- ex_hold  out  1  hold ID/EX and insert bubble into EX/MEM.
- mc_busy  out  1  multi-cycle op in progress.
- halted  out  1  core halted.
- stall_cnt  out  CNT_W  cycles with pc_stall=1 outside HALT.

Behaviour:
- Reset (async): state=RUN, mc counter=0, stall_cnt=0. All outputs 0.
- State machine: RUN, MC_WAIT, HALT.
- Per-cycle hazard terms, combinational, in RUN only, all gated by id_valid:
  - lu: ex_memread & ex_regwrite & ((id_use1 & ex_rd==id_ra1) | (id_use2 & ex_rd==id_ra2)).
  - bh: id_is_branch & ((ex_regwrite & ex_rd==id_ra1) | (mem_memread & mem_regwrite & mem_rd==id_ra1) | (id_use_r0 & ex_r0write)).
  - stall = lu | bh.
- RUN with stall: pc_stall=ifid_stall=idex_bubble=1; ifid_flush=0, even if id_br_taken (branch re-evaluates next cycle).
- RUN without stall:
  - ifid_flush = id_is_branch & id_br_taken.
  - id_is_mc → next state MC_WAIT, counter loaded with MC_LAT-1.
  - id_halt → next state HALT (halt wins over mc if both are set).
- MC_WAIT:
  - Outputs: pc_stall=ifid_stall=ex_hold=mc_busy=1; idex_bubble=0.
  - Counter decrements each cycle; at 1, next state is RUN.
  - Total stall cycles = MC_LAT-1.
  - ID hazards are not evaluated; they are re-evaluated on return to RUN.
- HALT:
  - Outputs: pc_stall=1, ifid_flush=1, halted=1. The pipeline drains naturally.
  - Terminal until reset. stall_cnt frozen.
- stall_cnt increments when pc_stall=1 in RUN or MC_WAIT. It saturates at all-ones and does not wrap.
- Register-address compares are full REG_AW width. R0 writes are tracked only via ex_r0write.
- Reset mid-MC_WAIT returns to RUN immediately, counter=0, with no residual hold.
- Outputs are combinational from state plus inputs. State, counter and stall_cnt are registered.

Decomposition:
- Shared package (pipe_pkg):
  - state encoding constants ST_RUN=2'd0, ST_MC=2'd1, ST_HALT=2'd2.
  - REG_AW default, and the R0 index constant.
- One natural sub-module: sat_counter (CNT_W, enable, async reset), reused for perf counters elsewhere.

Test Plan:
- Load-use: ex_memread=1, ex_regwrite=1, ex_rd=3, id_ra1=3, id_use1=1 → exactly one cycle of pc_stall=ifid_stall=idex_bubble=1; stall_cnt=1.
- Branch hazard: id_is_branch=1, id_br_taken=1, mem_memread=1, mem_regwrite=1, mem_rd=5, id_ra1=5 → cycle 1 stall with ifid_flush=0; next cycle (mem clear) ifid_flush=1, no stall.
- Multi-cycle: id_is_mc=1, MC_LAT=4 → mc_busy=ex_hold=pc_stall=1 for 3 cycles, then RUN; stall_cnt=3. Repeat with MC_LAT=2 → 1 cycle.
- Halt: id_halt=1 with id_is_mc=1 → HALT next cycle, halted=1, pc_stall=1, ifid_flush=1 held for 20 cycles; stall_cnt unchanged.
- Saturation: CNT_W=4, force 20 load-use stalls → stall_cnt stops at 15.
- Async reset asserted mid-MC_WAIT between clock edges → all outputs 0 immediately; RUN after release with no hold.
